// File: rtl/divider_8b_seq.sv
// Sequential unsigned restoring divider: 2N-bit dividend / N-bit divisor,
// one quotient bit per clock, valid/ready handshake on both sides.
module divider_8b_seq #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] quotient,
  output logic [N-1:0]   remainder,
  output logic           dbz
);

  localparam int CW = $clog2(2*N+1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(2*N);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [2*N-1:0] q_q, q_d;
  logic [N:0]     pr_q, pr_d;
  logic [N-1:0]   div_q, div_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] quot_q, quot_d;
  logic [N-1:0]   rem_q, rem_d;
  logic           dbz_q, dbz_d;

  logic [N:0]     pr_step;
  logic [2*N-1:0] q_step;

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    pr_d    = pr_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    pr_step = {pr_q[N-1:0], q_q[2*N-1]};
    q_step  = {q_q[2*N-2:0], 1'b0};
    if (pr_step >= {1'b0, div_q}) begin
      pr_step   = pr_step - {1'b0, div_q};
      q_step[0] = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (divisor != '0) begin
            div_d   = divisor;
            q_d     = dividend;
            pr_d    = '0;
            cnt_d   = CNT_LOAD;
            state_d = S_BUSY;
          end else begin
            quot_d  = '1;
            rem_d   = '0;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_BUSY: begin
        q_d   = q_step;
        pr_d  = pr_step;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          quot_d  = q_step;
          rem_d   = pr_step[N-1:0];
          dbz_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      pr_q    <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      pr_q    <= pr_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  // Handshake outputs are masked while reset is asserted.
  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = (state_q == S_DONE) && !rst;
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign dbz       = dbz_q;

endmodule
